// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential mantissa divider: FSM encoding and
// iteration-count helpers derived from the quotient width and bits per clock.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned iter_count(input int unsigned q_w,
                                             input int unsigned steps);
    return q_w / steps;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned q_w,
                                            input int unsigned steps);
    return $clog2(iter_count(q_w, steps) + 1);
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One combinational restoring-division cell: compare, conditionally subtract,
// then shift the partial remainder left by one.
module fp_div_step
  import fp_div_pkg::*;
#(
  parameter int unsigned MANT_W = 24
) (
  input  logic [MANT_W:0]   rem_i,
  input  logic [MANT_W-1:0] div_i,
  output logic              q_o,
  output logic [MANT_W:0]   rem_o
);

  logic [MANT_W:0] div_ext;
  logic [MANT_W:0] diff;

  assign div_ext = {1'b0, div_i};
  assign q_o     = (rem_i >= div_ext);
  assign diff    = q_o ? (rem_i - div_ext) : rem_i;
  // Top bit of diff is always clear for normalised operands, so the shift is lossless.
  assign rem_o   = diff << 1;

endmodule

// File: rtl/fp_mant_div_seq.sv
// Multi-cycle restoring divider for normalised FP mantissas; retires STEPS
// quotient bits per clock and reports a sticky bit for the rounder.
module fp_mant_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned Q_W    = 26,
  parameter int unsigned STEPS  = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic              in_abort,
  input  logic [MANT_W-1:0] in_dividend,
  input  logic [MANT_W-1:0] in_divisor,
  output logic              out_busy,
  output logic              out_valid,
  output logic [Q_W-1:0]    out_quotient,
  output logic              out_sticky,
  output logic              out_div_zero
);

  localparam int unsigned ITERS = iter_count(Q_W, STEPS);
  localparam int unsigned CNT_W = cnt_width(Q_W, STEPS);

  if ((Q_W % STEPS) != 0) begin : g_bad_steps
    $error("fp_mant_div_seq: Q_W must be a multiple of STEPS");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] div_q, div_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [Q_W-1:0]    res_quo_q, res_quo_d;
  logic              res_sticky_q, res_sticky_d;
  logic              res_dz_q, res_dz_d;

  logic [MANT_W:0]   rem_chain [STEPS+1];
  logic [STEPS-1:0]  q_bits;
  logic [Q_W-1:0]    quo_step;

  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < int'(STEPS); i++) begin : g_step
    fp_div_step #(
      .MANT_W(MANT_W)
    ) u_step (
      .rem_i(rem_chain[i]),
      .div_i(div_q),
      .q_o  (q_bits[i]),
      .rem_o(rem_chain[i+1])
    );
  end

  // Earlier cells in the chain produce the more significant quotient bits.
  always_comb begin
    quo_step = quo_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      quo_step = {quo_step[Q_W-2:0], q_bits[i]};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    div_d        = div_q;
    quo_d        = quo_q;
    res_quo_d    = res_quo_q;
    res_sticky_d = res_sticky_q;
    res_dz_d     = res_dz_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (in_start) begin
          if (in_divisor == '0) begin
            state_d      = ST_DONE;
            res_quo_d    = '1;
            res_sticky_d = 1'b1;
            res_dz_d     = 1'b1;
          end else begin
            state_d = ST_RUN;
            rem_d   = {1'b0, in_dividend};
            div_d   = in_divisor;
            quo_d   = '0;
            cnt_d   = CNT_W'(ITERS);
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_chain[STEPS];
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d      = ST_DONE;
            res_quo_d    = quo_step;
            res_sticky_d = (rem_chain[STEPS] != '0);
            res_dz_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      quo_q        <= '0;
      res_quo_q    <= '0;
      res_sticky_q <= 1'b0;
      res_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      quo_q        <= quo_d;
      res_quo_q    <= res_quo_d;
      res_sticky_q <= res_sticky_d;
      res_dz_q     <= res_dz_d;
    end
  end

  assign out_busy     = (state_q == ST_RUN);
  assign out_valid    = (state_q == ST_DONE);
  assign out_quotient = res_quo_q;
  assign out_sticky   = res_sticky_q;
  assign out_div_zero = res_dz_q;

endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Scoreboard bench for fp_mant_div_seq: drivers push expected results, monitors
// pop and compare whenever out_valid is seen.
module tb_fp_mant_div_seq;

  typedef struct packed {
    logic [25:0] q;
    logic        st;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [23:0] a, d;
  logic        busy, valid, sticky, dz;
  logic [25:0] quo;

  logic        start2, abort2;
  logic [23:0] a2, d2;
  logic        busy2, valid2, sticky2, dz2;
  logic [25:0] quo2;

  exp_t        sb[$];
  exp_t        sb2[$];
  int unsigned cyc   = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mant_div_seq #(.MANT_W(24), .Q_W(26), .STEPS(1)) dut (
    .in_clk(clk), .in_rst(rst), .in_start(start), .in_abort(abort),
    .in_dividend(a), .in_divisor(d),
    .out_busy(busy), .out_valid(valid), .out_quotient(quo),
    .out_sticky(sticky), .out_div_zero(dz)
  );

  fp_mant_div_seq #(.MANT_W(24), .Q_W(26), .STEPS(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_start(start2), .in_abort(abort2),
    .in_dividend(a2), .in_divisor(d2),
    .out_busy(busy2), .out_valid(valid2), .out_quotient(quo2),
    .out_sticky(sticky2), .out_div_zero(dz2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient = floor(a * 2^25 / d), sticky = remainder non-zero.
  function automatic exp_t model(input logic [23:0] aa, input logic [23:0] dd,
                                 input int unsigned c);
    exp_t e;
    longint unsigned n;
    if (dd == 24'd0) begin
      e = exp_t'{q: '1, st: 1'b1, dz: 1'b1, cyc: c + 1};
    end else begin
      n = longint'({40'd0, aa}) << 25;
      e = exp_t'{q: 26'(n / longint'({40'd0, dd})),
                 st: ((n % longint'({40'd0, dd})) != 0), dz: 1'b0, cyc: c + 27};
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      check("busy_valid_excl", 32'(busy & valid), 32'd0);
      if (valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quo), 32'(e.q));
          check("sticky", 32'(sticky), 32'(e.st));
          check("div_zero", 32'(dz), 32'(e.dz));
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst) begin
      check("s2_busy_valid_excl", 32'(busy2 & valid2), 32'd0);
      if (valid2) begin
        if (sb2.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL s2_unexpected_valid: actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb2.pop_front();
          check("s2_quotient", 32'(quo2), 32'(e.q));
          check("s2_sticky", 32'(sticky2), 32'(e.st));
          check("s2_div_zero", 32'(dz2), 32'(e.dz));
          check("s2_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected latency counts edges: capture edge is cyc+1, result visible 26 edges later.
  task automatic push1(input logic [23:0] aa, input logic [23:0] dd,
                       input logic [25:0] q, input logic st, input logic z);
    a = aa; d = dd; start = 1'b1;
    sb.push_back(exp_t'{q: q, st: st, dz: z, cyc: cyc + 1 + (z ? 0 : 26)});
  endtask

  task automatic run1(input logic [23:0] aa, input logic [23:0] dd,
                      input logic [25:0] q, input logic st, input logic z);
    push1(aa, dd, q, st, z);
    tick();
    start = 1'b0;
  endtask

  task automatic run2(input logic [23:0] aa, input logic [23:0] dd,
                      input logic [25:0] q, input logic st);
    a2 = aa; d2 = dd; start2 = 1'b1;
    sb2.push_back(exp_t'{q: q, st: st, dz: 1'b0, cyc: cyc + 1 + 13});
    tick();
    start2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || sb2.size() != 0); i++) tick();
    tick();
    check("drain_pending", 32'(sb.size() + sb2.size()), 32'd0);
    sb.delete();
    sb2.delete();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid) return;
    end
    check("wait_valid_timeout", 32'(valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra, rd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; d = '0;
    start2 = 1'b0; abort2 = 1'b0; a2 = '0; d2 = '0;
    repeat (3) tick();
    check("rst_quotient", 32'(quo), 32'd0);
    check("rst_flags", 32'({busy, valid, sticky, dz}), 32'd0);
    check("s2_rst_quotient", 32'(quo2), 32'd0);
    rst = 1'b0;
    tick();

    run1(24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0); drain();
    run1(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0); drain();
    run1(24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0); drain();
    run1(24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 1'b0); drain();
    run1(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0); drain();
    run2(24'h800000, 24'hC00000, 26'h1555555, 1'b1);       drain();
    run2(24'hC00000, 24'h800000, 26'h3000000, 1'b0);       drain();
    run1(24'hABCDEF, 24'h000000, 26'h3FFFFFF, 1'b1, 1'b1); drain();

    // start during RUN must be ignored
    run1(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0);
    repeat (4) tick();
    a = 24'hFFFFFF; d = 24'h800000; start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // abort mid-RUN: IDLE next cycle, no valid, previous results held
    run1(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_hold_quotient", 32'(quo), 32'h1555555);
    check("abort_hold_sticky", 32'(sticky), 32'd1);
    repeat (30) tick();

    // abort beats start inside RUN
    run1(24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0);
    repeat (3) tick();
    abort = 1'b1; start = 1'b1; a = 24'hC00000; d = 24'h800000;
    tick();
    abort = 1'b0; start = 1'b0;
    void'(sb.pop_back());
    check("abort_start_busy", 32'(busy), 32'd0);
    repeat (30) tick();

    // abort in IDLE has no effect
    abort = 1'b1;
    run1(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0);
    abort = 1'b0;
    drain();

    // back-to-back: start held, new operands each valid cycle
    ra = 24'h800000 | 24'($urandom());
    rd = 24'h800000 | 24'($urandom());
    a = ra; d = rd; start = 1'b1;
    sb.push_back(model(ra, rd, cyc));
    for (int k = 1; k < 100; k++) begin
      wait_valid();
      ra = 24'h800000 | 24'($urandom());
      rd = 24'h800000 | 24'($urandom());
      a = ra; d = rd;
      sb.push_back(model(ra, rd, cyc));
    end
    wait_valid();
    start = 1'b0;
    drain();

    // reset mid-RUN clears everything without a valid pulse
    run1(24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    void'(sb.pop_back());
    check("midrst_quotient", 32'(quo), 32'd0);
    check("midrst_flags", 32'({busy, valid, sticky, dz}), 32'd0);
    rst = 1'b0;
    tick();
    run1(24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
